// File: rtl/alu_muldiv_pkg.sv
// Shared opcode, engine-mode and FSM-state types for the accumulator ALU.
package alu_muldiv_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_ADD  = 5'b00001,
        OP_SUB  = 5'b00010,
        OP_SLA  = 5'b00011,
        OP_SRA  = 5'b00100,
        OP_SLL  = 5'b00101,
        OP_SRL  = 5'b00110,
        OP_AND  = 5'b00111,
        OP_OR   = 5'b01000,
        OP_XOR  = 5'b01001,
        OP_CL   = 5'b01010,
        OP_CG   = 5'b01011,
        OP_CE   = 5'b01100,
        OP_ADC  = 5'b01101,
        OP_SBB  = 5'b01110,
        OP_NOTF = 5'b10000,
        OP_MUL  = 5'b10001,
        OP_DIV  = 5'b10010,
        OP_MOD  = 5'b10011,
        OP_MFHI = 5'b10100
    } opcode_e;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIV,
        MD_MOD
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } md_state_e;

    // Signed overflow from operand/result sign bits.
    function automatic logic add_ovf(input logic a, input logic b, input logic r);
        return (a == b) && (r != a);
    endfunction

    function automatic logic sub_ovf(input logic a, input logic b, input logic r);
        return (a != b) && (r != a);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Control-unit side of the ALU: opcode/operand/strobes in, status out.
interface alu_muldiv_if #(
    parameter int W = 16
) ();
    logic [4:0]   opcode;
    logic [W-1:0] operand;
    logic         read;
    logic         write;
    logic         writeu;
    logic         flag;
    logic         carry;
    logic         zero;
    logic         ovf;
    logic         busy;

    modport master (
        output opcode, operand, read, write, writeu,
        input  flag, carry, zero, ovf, busy
    );

    modport slave (
        input  opcode, operand, read, write, writeu,
        output flag, carry, zero, ovf, busy
    );
endinterface

// File: rtl/alu_muldiv_seq_muldiv.sv
// W-cycle unsigned shift-add multiplier / restoring divider sharing one 2W register.
module alu_seq_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  md_op_e       op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi,
    output logic         res_flag
);
    localparam int CW = $clog2(W);

    md_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] p_q, p_d, p_step;
    logic [W-1:0]   m_q, m_d;
    logic           mod_q, mod_d;
    logic [W:0]     sum, trial;

    assign div0 = start && (op != MD_MUL) && (b == '0);
    assign busy = (state_q != S_IDLE);

    // One iteration: MUL adds and shifts right, DIV shifts left and trial-subtracts.
    always_comb begin
        sum    = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
        trial  = {p_q[2*W-1:W], p_q[W-1]} - {1'b0, m_q};
        p_step = p_q;
        if (state_q == S_MUL) begin
            p_step = {sum, p_q[W-1:1]};
        end else if (!trial[W]) begin
            p_step = {trial[W-1:0], p_q[W-2:0], 1'b1};
        end else begin
            p_step = {p_q[2*W-2:0], 1'b0};
        end
    end

    // Next-state, iteration counter and result mux.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        mod_d    = mod_q;
        done     = 1'b0;
        res_lo   = p_step[W-1:0];
        res_hi   = p_step[2*W-1:W];
        res_flag = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !div0) begin
                    p_d     = {{W{1'b0}}, a};
                    m_d     = b;
                    cnt_d   = '0;
                    mod_d   = (op == MD_MOD);
                    state_d = (op == MD_MUL) ? S_MUL : S_DIV;
                end
            end
            default: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase

        if (state_q == S_MUL) begin
            res_flag = (p_step[2*W-1:W] != '0);
        end else if (mod_q) begin
            res_lo = p_step[2*W-1:W];
            res_hi = p_step[W-1:0];
        end

        if (div0) begin
            res_lo   = (op == MD_DIV) ? '1 : a;
            res_hi   = a;
            res_flag = 1'b1;
        end
    end

    // Engine state register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            mod_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            mod_q   <= mod_d;
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// Accumulator ALU: acc/hi/flags, single-cycle ops, write priority and bus tri-state.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int W       = 16,
    parameter int UPPER_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_muldiv_if.slave  bus,
    output logic [W-1:0] accout
);
    localparam int           SH_W  = $clog2(W) + 1;
    localparam int           W1    = W + 1;
    localparam logic [W-1:0] W_VAL = W'(W);

    logic [W-1:0] acc_q, acc_d, hi_q, hi_d;
    logic         flag_q, flag_d, carry_q, carry_d, ovf_q, ovf_d;
    logic         md_start, md_busy, md_done, md_div0, md_flag;
    md_op_e       md_op;
    logic [W-1:0] md_lo, md_hi;
    logic [SH_W-1:0] sh;
    logic [W:0]   shl_ext, arith;

    alu_seq_muldiv #(.W(W)) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (md_start),
        .op       (md_op),
        .a        (acc_q),
        .b        (bus.operand),
        .busy     (md_busy),
        .done     (md_done),
        .div0     (md_div0),
        .res_lo   (md_lo),
        .res_hi   (md_hi),
        .res_flag (md_flag)
    );

    assign accout    = bus.read ? acc_q : 'z;
    assign bus.flag  = flag_q;
    assign bus.carry = carry_q;
    assign bus.ovf   = ovf_q;
    assign bus.zero  = (acc_q == '0);
    assign bus.busy  = md_busy;

    // Issue decode for the multi-cycle engine, kept apart from the result path.
    always_comb begin
        md_start = 1'b0;
        md_op    = MD_MUL;
        if (!md_busy) begin
            case (bus.opcode)
                OP_MUL: md_start = 1'b1;
                OP_DIV: begin md_start = 1'b1; md_op = MD_DIV; end
                OP_MOD: begin md_start = 1'b1; md_op = MD_MOD; end
                default: ;
            endcase
        end
    end

    // Next accumulator/flags: engine result, else write, writeu, then ALU op on top.
    always_comb begin
        acc_d   = acc_q;
        hi_d    = hi_q;
        flag_d  = flag_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        arith   = '0;
        sh      = (bus.operand >= W_VAL) ? SH_W'(W) : SH_W'(bus.operand);
        shl_ext = {1'b0, acc_q} << sh;

        if (md_done) begin
            acc_d  = md_lo;
            hi_d   = md_hi;
            flag_d = md_flag;
        end else if (!md_busy) begin
            if (bus.write)  acc_d = bus.operand;
            if (bus.writeu) acc_d[W-1 -: UPPER_W] = bus.operand[UPPER_W-1:0];
            case (bus.opcode)
                OP_ADD, OP_ADC: begin
                    arith   = {1'b0, acc_q} + {1'b0, bus.operand}
                              + W1'((bus.opcode == OP_ADC) && carry_q);
                    acc_d   = arith[W-1:0];
                    carry_d = arith[W];
                    ovf_d   = add_ovf(acc_q[W-1], bus.operand[W-1], arith[W-1]);
                end
                OP_SUB, OP_SBB: begin
                    arith   = {1'b0, acc_q} - {1'b0, bus.operand}
                              - W1'((bus.opcode == OP_SBB) && carry_q);
                    acc_d   = arith[W-1:0];
                    carry_d = arith[W];
                    ovf_d   = sub_ovf(acc_q[W-1], bus.operand[W-1], arith[W-1]);
                end
                OP_SLA, OP_SLL: begin
                    acc_d   = shl_ext[W-1:0];
                    carry_d = shl_ext[W];
                end
                OP_SRA: begin
                    acc_d   = $unsigned($signed(acc_q) >>> sh);
                    carry_d = 1'b0;
                end
                OP_SRL: begin
                    acc_d   = acc_q >> sh;
                    carry_d = 1'b0;
                end
                OP_AND: begin acc_d = acc_q & bus.operand; carry_d = 1'b0; end
                OP_OR:  begin acc_d = acc_q | bus.operand; carry_d = 1'b0; end
                OP_XOR: begin acc_d = acc_q ^ bus.operand; carry_d = 1'b0; end
                OP_CL:   flag_d = ($signed(acc_q) < $signed(bus.operand));
                OP_CG:   flag_d = ($signed(acc_q) > $signed(bus.operand));
                OP_CE:   flag_d = (acc_q == bus.operand);
                OP_NOTF: flag_d = ~flag_q;
                OP_MFHI: acc_d  = hi_q;
                OP_DIV, OP_MOD: begin
                    if (md_div0) begin
                        acc_d  = md_lo;
                        hi_d   = md_hi;
                        flag_d = md_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    // Architectural state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            hi_q    <= '0;
            flag_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            flag_q  <= flag_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed vector table plus hand sequences for MUL/DIV/MOD, divide-by-zero and reset abort.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [15:0] accout;
    int          n_pass = 0;
    int          n_total = 0;

    alu_muldiv_if #(.W(16)) bus ();

    alu_muldiv #(.W(16), .UPPER_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .accout (accout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] opnd;
        logic        wr;
        logic        wru;
        logic [15:0] acc;
        logic        flag;
        logic        carry;
        logic        ovf;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycle(input logic [4:0] op, input logic [15:0] opnd,
                         input logic wr, input logic wru);
        bus.opcode  = op;
        bus.operand = opnd;
        bus.write   = wr;
        bus.writeu  = wru;
        @(posedge clk);
        #1;
        bus.opcode  = 5'h00;
        bus.write   = 1'b0;
        bus.writeu  = 1'b0;
    endtask

    task automatic state_chk(input string tag, input logic [15:0] acc, input logic flag,
                             input logic carry, input logic ovf);
        chk({tag, "_acc"},   32'(accout),   32'(acc));
        chk({tag, "_flag"},  32'(bus.flag), 32'(flag));
        chk({tag, "_carry"}, 32'(bus.carry), 32'(carry));
        chk({tag, "_ovf"},   32'(bus.ovf),  32'(ovf));
        chk({tag, "_zero"},  32'(bus.zero), 32'(acc == 16'h0000));
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    endtask

    // Counts busy cycles after issue, bounded so a stuck engine still ends the run.
    task automatic wait_busy(output int n);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            bus.opcode  = 5'b00001;
            bus.operand = 16'hFFFF;
            bus.write   = 1'b1;
            bus.writeu  = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.opcode = 5'h00;
        bus.write  = 1'b0;
        bus.writeu = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0]  = '{5'h00, 16'h7FFF, 1, 0, 16'h7FFF, 0, 0, 0};
        vecs[1]  = '{5'h01, 16'h0001, 0, 0, 16'h8000, 0, 0, 1};
        vecs[2]  = '{5'h00, 16'h0000, 1, 0, 16'h0000, 0, 0, 1};
        vecs[3]  = '{5'h02, 16'h0001, 0, 0, 16'hFFFF, 0, 1, 0};
        vecs[4]  = '{5'h0E, 16'h0000, 0, 0, 16'hFFFE, 0, 0, 0};
        vecs[5]  = '{5'h00, 16'h8000, 1, 0, 16'h8000, 0, 0, 0};
        vecs[6]  = '{5'h0A, 16'h0001, 0, 0, 16'h8000, 1, 0, 0};
        vecs[7]  = '{5'h0B, 16'h0001, 0, 0, 16'h8000, 0, 0, 0};
        vecs[8]  = '{5'h0C, 16'h8000, 0, 0, 16'h8000, 1, 0, 0};
        vecs[9]  = '{5'h10, 16'h0000, 0, 0, 16'h8000, 0, 0, 0};
        vecs[10] = '{5'h07, 16'h0F3C, 1, 0, 16'h0000, 0, 0, 0};
        vecs[11] = '{5'h00, 16'h00F0, 1, 0, 16'h00F0, 0, 0, 0};
        vecs[12] = '{5'h08, 16'h0F0F, 0, 0, 16'h0FFF, 0, 0, 0};
        vecs[13] = '{5'h09, 16'h00FF, 0, 0, 16'h0F00, 0, 0, 0};
        vecs[14] = '{5'h05, 16'h0004, 0, 0, 16'hF000, 0, 0, 0};
        vecs[15] = '{5'h03, 16'h0001, 0, 0, 16'hE000, 0, 1, 0};
        vecs[16] = '{5'h07, 16'hFFFF, 0, 0, 16'hE000, 0, 0, 0};
        vecs[17] = '{5'h04, 16'h0004, 0, 0, 16'hFE00, 0, 0, 0};
        vecs[18] = '{5'h06, 16'h0008, 0, 0, 16'h00FE, 0, 0, 0};
        vecs[19] = '{5'h00, 16'h8001, 1, 0, 16'h8001, 0, 0, 0};
        vecs[20] = '{5'h05, 16'h0100, 0, 0, 16'h0000, 0, 1, 0};
        vecs[21] = '{5'h00, 16'h8001, 1, 0, 16'h8001, 0, 1, 0};
        vecs[22] = '{5'h04, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 0};
        vecs[23] = '{5'h01, 16'h0001, 0, 0, 16'h0000, 0, 1, 0};
        vecs[24] = '{5'h0D, 16'h7FFF, 0, 0, 16'h8000, 0, 0, 1};
        vecs[25] = '{5'h00, 16'h000A, 1, 1, 16'hA00A, 0, 0, 1};
        vecs[26] = '{5'h00, 16'h0005, 0, 1, 16'h500A, 0, 0, 1};
        vecs[27] = '{5'h1F, 16'h0033, 1, 0, 16'h0033, 0, 0, 1};
        vecs[28] = '{5'h0F, 16'h0000, 0, 0, 16'h0033, 0, 0, 1};
        vecs[29] = '{5'h14, 16'h0000, 0, 0, 16'h0000, 0, 0, 1};

        bus.opcode  = 5'h00;
        bus.operand = 16'h0000;
        bus.read    = 1'b1;
        bus.write   = 1'b0;
        bus.writeu  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        state_chk("reset", 16'h0000, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].op, vecs[i].opnd, vecs[i].wr, vecs[i].wru);
            state_chk($sformatf("v%0d", i), vecs[i].acc, vecs[i].flag,
                      vecs[i].carry, vecs[i].ovf);
        end

        // MUL 0x1234 * 0x0100 with inputs toggled while busy
        cycle(5'h00, 16'h1234, 1, 0);
        cycle(5'h11, 16'h0100, 0, 0);
        chk("mul_busy_rise", 32'(bus.busy), 32'd1);
        wait_busy(n);
        chk("mul_busy_cycles", 32'(n), 32'd16);
        state_chk("mul", 16'h3400, 1, 0, 1);
        cycle(5'h14, 16'h0000, 0, 0);
        state_chk("mul_mfhi", 16'h0012, 1, 0, 1);

        // DIV and MOD 100 / 7
        cycle(5'h00, 16'h0064, 1, 0);
        cycle(5'h12, 16'h0007, 0, 0);
        wait_busy(n);
        chk("div_busy_cycles", 32'(n), 32'd16);
        state_chk("div", 16'h000E, 0, 0, 1);
        cycle(5'h14, 16'h0000, 0, 0);
        state_chk("div_mfhi", 16'h0002, 0, 0, 1);
        cycle(5'h00, 16'h0064, 1, 0);
        cycle(5'h13, 16'h0007, 0, 0);
        wait_busy(n);
        chk("mod_busy_cycles", 32'(n), 32'd16);
        state_chk("mod", 16'h0002, 0, 0, 1);
        cycle(5'h14, 16'h0000, 0, 0);
        state_chk("mod_mfhi", 16'h000E, 0, 0, 1);

        // Divide by zero never raises busy
        cycle(5'h00, 16'h0064, 1, 0);
        cycle(5'h12, 16'h0000, 0, 0);
        state_chk("div0", 16'hFFFF, 1, 0, 1);
        cycle(5'h00, 16'h0000, 0, 0);
        state_chk("div0_idle", 16'hFFFF, 1, 0, 1);
        cycle(5'h14, 16'h0000, 0, 0);
        state_chk("div0_mfhi", 16'h0064, 1, 0, 1);
        cycle(5'h10, 16'h0000, 0, 0);
        cycle(5'h00, 16'h0065, 1, 0);
        cycle(5'h13, 16'h0000, 0, 0);
        state_chk("mod0", 16'h0065, 1, 0, 1);
        cycle(5'h14, 16'h0000, 0, 0);
        state_chk("mod0_mfhi", 16'h0065, 1, 0, 1);

        // Reset during busy cycle 5 aborts the multiply
        cycle(5'h00, 16'h1234, 1, 0);
        cycle(5'h11, 16'h0100, 0, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_c5", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        state_chk("abort", 16'h0000, 0, 0, 0);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        state_chk("abort_late", 16'h0000, 0, 0, 0);
        cycle(5'h14, 16'h0000, 0, 0);
        state_chk("abort_mfhi", 16'h0000, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
